fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based request issue, in-order FIFO of {pc, instr}, redirect flush.
// Optional same-cycle response bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_pc_q;
    logic             inflight_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic empty;
    logic resp;
    logic bypass;
    logic push;
    logic pop;
    logic pop_q;

    always_comb begin
        empty = (occ_q == '0);
        // Responses are only accepted for a request we actually issued last cycle.
        resp  = imem_valid && inflight_q && !redirect;
        // Credits count queued entries plus the read in flight; a same-cycle pop frees nothing.
        imem_req = rstn && !redirect && ((occ_q + OCC_W'(inflight_q)) < DEPTH_C);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty && resp;
`else
        bypass = 1'b0;
`endif
        out_valid = !redirect && (!empty || bypass);
        pop       = out_valid && out_ready;
        pop_q     = pop && !empty;
        push      = resp && !(bypass && out_ready);
        occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop_q);

        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            if (bypass) begin
                out_pc    = req_pc_q;
                out_instr = imem_rdata;
            end else begin
                out_pc    = pc_mem[rd_ptr_q];
                out_instr = instr_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            req_pc_q   <= fetch_pc_q;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc_q <= fetch_pc_q + 32'd1;
            end
            req_pc_q   <= fetch_pc_q;
            inflight_q <= imem_req;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_q) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    // Storage needs no reset: reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences, random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rstn;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_valid;
    logic [31:0]            imem_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_pc;
    logic [31:0]            out_instr;
    logic [$clog2(DEPTH):0] occupancy;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending entries in fetch order plus the one outstanding request.
    logic [31:0] mq_pc[$];
    logic [31:0] m_fetch;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    bit          env_req;
    logic [31:0] env_addr;

    logic [31:0] s_req, s_addr, s_valid, s_pc, s_instr, s_occ;
    bit          model_chk = 1'b1;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] occ;
    } vec_t;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample/compare at negedge, then advance model and memory after posedge.
    task automatic tick();
        bit          resp, e_req, byp, e_valid, pop;
        int          sz;
        logic [31:0] e_pc;
        @(negedge clk);
        s_req   = 32'(imem_req);
        s_addr  = imem_addr;
        s_valid = 32'(out_valid);
        s_pc    = out_pc;
        s_instr = out_instr;
        s_occ   = 32'(occupancy);
        sz      = mq_pc.size();
        resp    = imem_valid && m_pend && !redirect;
        e_req   = !redirect && ((sz + int'(m_pend)) < int'(DEPTH));
        byp     = BYP && (sz == 0) && resp;
        e_valid = !redirect && (sz > 0 || byp);
        e_pc    = (sz > 0) ? mq_pc[0] : m_pend_pc;
        if (model_chk) begin
            check("m_imem_req", s_req, 32'(e_req));
            check("m_imem_addr", s_addr, m_fetch);
            check("m_out_valid", s_valid, 32'(e_valid));
            check("m_occupancy", s_occ, 32'(sz));
            if (e_valid) begin
                check("m_out_pc", s_pc, e_pc);
                check("m_out_instr", s_instr, word_of(e_pc));
            end
        end
        env_req  = imem_req;
        env_addr = imem_addr;
        pop      = e_valid && out_ready;
        @(posedge clk);
        #1;
        if (redirect) begin
            mq_pc.delete();
            m_fetch = redirect_pc;
            m_pend  = 1'b0;
        end else begin
            if (pop && sz > 0) void'(mq_pc.pop_front());
            if (resp && !(byp && pop)) mq_pc.push_back(m_pend_pc);
            m_pend    = e_req;
            m_pend_pc = m_fetch;
            if (e_req) m_fetch = m_fetch + 32'd1;
        end
        imem_valid = env_req;
        imem_rdata = word_of(env_addr);
    endtask

    // Asynchronous reset pulse; glitch drives a spurious imem_valid in the first cycle after release.
    task automatic do_reset(input bit glitch);
        redirect = 1'b0;
        rstn     = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        mq_pc.delete();
        m_fetch    = RESET_PC;
        m_pend     = 1'b0;
        m_pend_pc  = '0;
        imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn       = 1'b1;
        imem_valid = glitch;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    initial begin
        vec_t        tbl[6];
        bit          found;
        bit          have_last;
        logic [31:0] last_pc;

        rstn        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        out_ready   = 1'b0;
        #2;

        // Startup with word-addressed memory and out_ready held high.
        if (BYP) begin
            tbl = '{'{1'b1, 32'd0, 1'b0, 32'd0, 32'd0}, '{1'b1, 32'd1, 1'b1, 32'd0, 32'd0},
                    '{1'b1, 32'd2, 1'b1, 32'd1, 32'd0}, '{1'b1, 32'd3, 1'b1, 32'd2, 32'd0},
                    '{1'b1, 32'd4, 1'b1, 32'd3, 32'd0}, '{1'b1, 32'd5, 1'b1, 32'd4, 32'd0}};
        end else begin
            tbl = '{'{1'b1, 32'd0, 1'b0, 32'd0, 32'd0}, '{1'b1, 32'd1, 1'b0, 32'd0, 32'd0},
                    '{1'b1, 32'd2, 1'b1, 32'd0, 32'd1}, '{1'b1, 32'd3, 1'b1, 32'd1, 32'd1},
                    '{1'b1, 32'd4, 1'b1, 32'd2, 32'd1}, '{1'b1, 32'd5, 1'b1, 32'd3, 32'd1}};
        end
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("tbl_req", s_req, 32'(tbl[k].req));
            check("tbl_addr", s_addr, tbl[k].addr);
            check("tbl_valid", s_valid, 32'(tbl[k].valid));
            check("tbl_occ", s_occ, tbl[k].occ);
            if (tbl[k].valid) begin
                check("tbl_pc", s_pc, tbl[k].pc);
                check("tbl_instr", s_instr, word_of(tbl[k].pc));
            end
        end

        // Stall until full, then drain in order; spurious imem_valid after release is ignored.
        do_reset(1'b1);
        out_ready = 1'b0;
        repeat (10) tick();
        check("stall_occ", s_occ, 32'(DEPTH));
        check("stall_req", s_req, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_valid", s_valid, 32'd1);
            check("drain_pc", s_pc, 32'(i));
        end

        // Redirect with three entries queued and one read in flight.
        do_reset(1'b0);
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (mq_pc.size() == 3) && m_pend;
        end
        check("reach_occ3", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("redir_valid", s_valid, 32'd0);
        check("redir_req", s_req, 32'd0);
        redirect = 1'b0;
        tick();
        check("post_redir_occ", s_occ, 32'd0);
        check("post_redir_addr", s_addr, 32'h40);
        check("post_redir_req", s_req, 32'd1);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_valid == 32'd1) begin
                found = 1'b1;
                check("redir_first_pc", s_pc, 32'h40);
            end
        end
        check("redir_out_seen", 32'(found), 32'd1);

        // Back-to-back redirects: the last wins.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        check("b2b_addr", s_addr, 32'h200);

        // Fetch PC wraps at 2^32.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_addr0", s_addr, 32'hFFFF_FFFF);
        tick();
        check("wrap_addr1", s_addr, 32'h0000_0000);
        repeat (6) tick();

        // Alternating out_ready: strictly consecutive PCs out, bounded occupancy.
        have_last = 1'b0;
        last_pc   = '0;
        for (int i = 0; i < 100; i++) begin
            out_ready = i[0];
            tick();
            check("occ_bound", 32'(s_occ <= 32'(DEPTH)), 32'd1);
            if (s_valid == 32'd1 && out_ready) begin
                if (have_last) check("consecutive_pc", s_pc, last_pc + 32'd1);
                have_last = 1'b1;
                last_pc   = s_pc;
            end
        end

        // Reset mid-stream at occupancy 2.
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        out_ready   = 1'b0;
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (s_occ == 32'd2);
        end
        check("reach_occ2", 32'(found), 32'd1);
        check("occ2_valid", s_valid, 32'd1);
        do_reset(1'b0);
        tick();
        check("rst_restart_addr", s_addr, RESET_PC);
        check("rst_restart_occ", s_occ, 32'd0);
        check("rst_restart_req", s_req, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                                      : $urandom;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                tick();
            end
        end
        redirect = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
